// File: rtl/uart_rx_frame_if.sv
// Result bundle produced by uart_rx_frame: the received byte, its strobe, busy and error pulses.
// The master side is the receiver; the slave side is the downstream consumer.
interface uart_rx_frame_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx_data,
        output rx_done,
        output rx_busy,
        output frame_err,
        output parity_err
    );

    modport slave (
        input rx_data,
        input rx_done,
        input rx_busy,
        input frame_err,
        input parity_err
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: synchronizes uart_rxd, samples 8N1 frames mid-bit and strobes each good byte.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a live parity_err pulse.
module uart_rx_frame #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int BIT_CYCLES = CLK_FREQ / UART_BPS
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    input  logic            uart_rxd,
    uart_rx_frame_if.master rx_if
);
    localparam int                CNT_W     = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
`ifdef UART_RX_PARITY_EN
        , PARITY = 3'd5
`endif
    } state_t;

    logic             sync1, sync2, prev;
    logic             start_edge;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift, shift_nx;
    logic [7:0]       data_q, data_nx;
    logic             done_q, done_nx;
    logic             ferr_q, ferr_nx;
    logic             busy_q, busy_nx;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_nx;
    logic             perr_q, perr_nx;
`endif

    // The line idles high, so presetting the synchronizer to 1 prevents a false start after reset.
    assign start_edge = prev & ~sync2;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        data_nx    = data_q;
        done_nx    = 1'b0;
        ferr_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nx = par_bad;
        perr_nx    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start_edge) state_nx = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx = '0;
                    if (sync2) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = sync2;
                    bit_idx_nx        = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx     = '0;
                    par_bad_nx = (sync2 != ^shift);
                    state_nx   = STOP;
                end
            end
`endif
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
                if (cnt == BIT_LAST) begin
                    cnt_nx = '0;
                    if (!sync2) begin
                        ferr_nx  = 1'b1;
                        state_nx = BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_nx  = 1'b1;
                        state_nx = IDLE;
`endif
                    end else begin
                        done_nx  = 1'b1;
                        data_nx  = shift;
                        state_nx = IDLE;
                    end
                end
            end
            BREAK: begin
                cnt_nx = '0;
                if (sync2) state_nx = IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync1   <= uart_rxd;
            sync2   <= sync1;
            prev    <= sync2;
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            data_q  <= data_nx;
            done_q  <= done_nx;
            ferr_q  <= ferr_nx;
            busy_q  <= busy_nx;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nx;
            perr_q  <= perr_nx;
`endif
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_done   = done_q;
    assign rx_if.rx_busy   = busy_q;
    assign rx_if.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
endmodule
